// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect types and constants for the write-path router.
package axi_ic_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } wr_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_decerr_slave_w.sv
// Internal default slave: accepts AW and W unconditionally and answers with DECERR.
module axi_decerr_slave_w
    import axi_ic_pkg::*;
#(
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  i_aw_en,
    input  logic                  i_w_en,
    input  logic                  i_b_en,
    input  logic [ID_WIDTH-1:0]   i_id,
    output logic                  o_awready,
    output logic                  o_wready,
    output logic                  o_bvalid,
    output logic [ID_WIDTH-1:0]   o_bid,
    output logic [1:0]            o_bresp,
    output logic [USER_WIDTH-1:0] o_buser
);

    assign o_awready = i_aw_en;
    assign o_wready  = i_w_en;
    assign o_bvalid  = i_b_en;
    assign o_bid     = i_b_en ? i_id : '0;
    assign o_bresp   = i_b_en ? RESP_DECERR : RESP_OKAY;
    assign o_buser   = '0;

endmodule

// File: rtl/axi_slave_mux_w_n.sv
// AXI write-path router: steers AW/W handshakes to one of NUM_SLAVES ports and muxes B back.
module axi_slave_mux_w_n
    import axi_ic_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 8,
    parameter int USER_WIDTH = 8,
    parameter int SEL_LSB    = 28
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [ADDR_WIDTH-1:0]            m_AWADDR,
    input  logic [ID_WIDTH-1:0]              m_AWID,
    input  logic                             m_AWVALID,
    output logic                             m_AWREADY,
    input  logic                             m_WVALID,
    input  logic                             m_WLAST,
    output logic                             m_WREADY,
    output logic [ID_WIDTH-1:0]              m_BID,
    output logic [1:0]                       m_BRESP,
    output logic [USER_WIDTH-1:0]            m_BUSER,
    output logic                             m_BVALID,
    input  logic                             m_BREADY,
    output logic [NUM_SLAVES-1:0]            s_AWVALID,
    input  logic [NUM_SLAVES-1:0]            s_AWREADY,
    output logic [NUM_SLAVES-1:0]            s_WVALID,
    input  logic [NUM_SLAVES-1:0]            s_WREADY,
    input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_BID,
    input  logic [NUM_SLAVES*2-1:0]          s_BRESP,
    input  logic [NUM_SLAVES*USER_WIDTH-1:0] s_BUSER,
    input  logic [NUM_SLAVES-1:0]            s_BVALID,
    output logic [NUM_SLAVES-1:0]            s_BREADY
);

    localparam int SEL_W = (clog2(NUM_SLAVES) < 1) ? 1 : clog2(NUM_SLAVES);

    wr_state_t             r_state;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_decerr;
    logic [ID_WIDTH-1:0]   r_id;

    logic [SEL_W-1:0]      w_field;
    logic                  w_unused_addr;
    logic                  w_in_addr;
    logic                  w_in_data;
    logic                  w_in_resp;
    logic                  w_sel_awready;
    logic                  w_sel_wready;
    logic                  w_sel_bvalid;
    logic [ID_WIDTH-1:0]   w_sel_bid;
    logic [1:0]            w_sel_bresp;
    logic [USER_WIDTH-1:0] w_sel_buser;
    logic                  w_dec_awready;
    logic                  w_dec_wready;
    logic                  w_dec_bvalid;
    logic [ID_WIDTH-1:0]   w_dec_bid;
    logic [1:0]            w_dec_bresp;
    logic [USER_WIDTH-1:0] w_dec_buser;

    assign w_field       = m_AWADDR[SEL_LSB +: SEL_W];
    assign w_unused_addr = ^m_AWADDR;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_decerr <= 1'b0;
            r_id     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_AWVALID) begin
                        r_sel    <= w_field;
                        r_id     <= m_AWID;
                        r_decerr <= (int'(w_field) >= NUM_SLAVES);
                        r_state  <= ADDR;
                    end
                end
                ADDR: if (m_AWVALID && m_AWREADY) r_state <= DATA;
                DATA: if (m_WVALID && m_WREADY && m_WLAST) r_state <= RESP;
                RESP: if (m_BVALID && m_BREADY) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is asserted, even mid-transaction.
    assign w_in_addr = !ARESET && (r_state == ADDR);
    assign w_in_data = !ARESET && (r_state == DATA);
    assign w_in_resp = !ARESET && (r_state == RESP);

    always_comb begin
        w_sel_awready = 1'b0;
        w_sel_wready  = 1'b0;
        w_sel_bvalid  = 1'b0;
        w_sel_bid     = '0;
        w_sel_bresp   = '0;
        w_sel_buser   = '0;
        s_AWVALID     = '0;
        s_WVALID      = '0;
        s_BREADY      = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (int'(r_sel) == k && !r_decerr) begin
                w_sel_awready = s_AWREADY[k];
                w_sel_wready  = s_WREADY[k];
                w_sel_bvalid  = s_BVALID[k];
                w_sel_bid     = s_BID[k*ID_WIDTH +: ID_WIDTH];
                w_sel_bresp   = s_BRESP[k*2 +: 2];
                w_sel_buser   = s_BUSER[k*USER_WIDTH +: USER_WIDTH];
                s_AWVALID[k]  = w_in_addr & m_AWVALID;
                s_WVALID[k]   = w_in_data & m_WVALID;
                s_BREADY[k]   = w_in_resp & m_BREADY;
            end
        end
    end

    axi_decerr_slave_w #(
        .ID_WIDTH   (ID_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_decerr (
        .i_aw_en   (w_in_addr & r_decerr),
        .i_w_en    (w_in_data & r_decerr),
        .i_b_en    (w_in_resp & r_decerr),
        .i_id      (r_id),
        .o_awready (w_dec_awready),
        .o_wready  (w_dec_wready),
        .o_bvalid  (w_dec_bvalid),
        .o_bid     (w_dec_bid),
        .o_bresp   (w_dec_bresp),
        .o_buser   (w_dec_buser)
    );

    assign m_AWREADY = r_decerr ? w_dec_awready : (w_in_addr & w_sel_awready);
    assign m_WREADY  = r_decerr ? w_dec_wready  : (w_in_data & w_sel_wready);
    assign m_BVALID  = r_decerr ? w_dec_bvalid  : (w_in_resp & w_sel_bvalid);
    assign m_BID     = r_decerr ? w_dec_bid     : (w_in_resp ? w_sel_bid   : '0);
    assign m_BRESP   = r_decerr ? w_dec_bresp   : (w_in_resp ? w_sel_bresp : '0);
    assign m_BUSER   = r_decerr ? w_dec_buser   : (w_in_resp ? w_sel_buser : '0);

endmodule

// File: doc/axi_slave_mux_w_n.md
Name: axi_slave_mux_w_n

Overview:
Parametrised write-path router for the AXI interconnect: one master-side write port fans out to NUM_SLAVES slave ports.
- Selects the slave from an address field and locks the route for one full transaction (AW, all W beats up to WLAST, B).
- Answers unmapped addresses internally with DECERR.
- AWADDR/WDATA/WSTRB/AW payload are broadcast to all slaves outside this block; this block steers only the handshakes and muxes the B channel back.

Parameters:
NUM_SLAVES, 4, number of slave ports (2..16, need not be a power of two)
ADDR_WIDTH, 64, width of m_AWADDR
ID_WIDTH, 8, AXI ID width
USER_WIDTH, 8, BUSER width
SEL_LSB, 28, lowest address bit of the slave-select field; field width SEL_W = clog2(NUM_SLAVES), minimum 1

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous reset, active-high
m_AWADDR  in  ADDR_WIDTH  write address from master
m_AWID  in  ID_WIDTH  write ID from master
m_AWVALID  in  1  master AW valid
m_AWREADY  out  1  AW ready to master
m_WVALID  in  1  master W valid
m_WLAST  in  1  last W beat
m_WREADY  out  1  W ready to master
m_BID  out  ID_WIDTH  response ID
m_BRESP  out  2  response code
m_BUSER  out  USER_WIDTH  response user
m_BVALID  out  1  response valid
m_BREADY  in  1  master B ready
s_AWVALID  out  NUM_SLAVES  per-slave AW valid
s_AWREADY  in  NUM_SLAVES  per-slave AW ready
s_WVALID  out  NUM_SLAVES  per-slave W valid
s_WREADY  in  NUM_SLAVES  per-slave W ready
s_BID  in  NUM_SLAVES*ID_WIDTH  packed per-slave BID, slave k at [k*ID_WIDTH +: ID_WIDTH]
s_BRESP  in  NUM_SLAVES*2  packed per-slave BRESP
s_BUSER  in  NUM_SLAVES*USER_WIDTH  packed per-slave BUSER
s_BVALID  in  NUM_SLAVES  per-slave B valid
s_BREADY  out  NUM_SLAVES  per-slave B ready

Behaviour:
- Interface fixed: one clock ACLK; reset ARESET is synchronous and active-high.
- State machine: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- Registers:
  - sel (SEL_W bits)
  - decerr flag
  - id_q (ID_WIDTH)
- Reset (ARESET=1 at a clock edge, also mid-transaction):
  - state=IDLE, sel=0, decerr=0, id_q=0.
  - All outputs 0 during and after reset until the FSM leaves IDLE.
  - An in-flight transaction is abandoned; no B is generated.
- IDLE:
  - All s_* valids/readies and all m_* readies/valid are 0.
  - If m_AWVALID=1: sel<=m_AWADDR[SEL_LSB +: SEL_W], id_q<=m_AWID, decerr<=(field >= NUM_SLAVES); go to ADDR.
  - Decode latency is 1 cycle; the master holds AWVALID per AXI.
- ADDR:
  - Mapped: s_AWVALID[sel]=m_AWVALID, m_AWREADY=s_AWREADY[sel].
  - decerr: m_AWREADY=1, no s_AWVALID asserted.
  - On m_AWVALID & m_AWREADY go to DATA.
- DATA:
  - Mapped: s_WVALID[sel]=m_WVALID, m_WREADY=s_WREADY[sel].
  - decerr: m_WREADY=1, beats sunk.
  - On a W handshake with m_WLAST=1 go to RESP.
  - Non-last beats stay in DATA; there is no beat-count limit.
- W before AW: W beats arriving in IDLE/ADDR see m_WREADY=0 and are stalled, never dropped.
- RESP:
  - Mapped: m_BVALID=s_BVALID[sel]; m_BID/m_BRESP/m_BUSER = slice sel of the packed inputs; s_BREADY[sel]=m_BREADY.
  - decerr: m_BVALID=1, m_BID=id_q, m_BRESP=2'b11, m_BUSER=0.
  - On m_BVALID & m_BREADY go to IDLE.
- Any unselected slave sees valid/ready=0 in every state. m_B* payload is 0 outside RESP.
- One outstanding transaction: a new AW is not accepted until B completes (m_AWREADY=0 in DATA/RESP).
- B arriving early from the selected slave (before WLAST) is not forwarded until RESP.
- All routing outputs are combinational from state/sel. No combinational path from m_AWADDR to outputs.

Decomposition:
- Package axi_ic_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum wr_state_t {IDLE, ADDR, DATA, RESP}.
  - clog2 helper.
- One natural sub-module, axi_decerr_slave_w: the AW/W sink and DECERR B generator, instantiated once and selected when decerr=1.

Test Plan:
- NUM_SLAVES=4: AW addr 0x2000_0000 (sel=2), 4 W beats with WLAST on beat 4, slave 2 BRESP=00 BID=0x5A -> only s_AWVALID[2]/s_WVALID[2] toggle; m_BID=0x5A, m_BRESP=00; FSM back in IDLE one cycle after B handshake.
- NUM_SLAVES=3: AW addr 0x3000_0000, AWID=0x11, 2 W beats -> no s_* valid asserted; m_AWREADY=1 in ADDR; 2 beats sunk; m_BVALID=1, m_BID=0x11, m_BRESP=11.
- Backpressure: slave 1 holds WREADY=0 for 5 cycles mid-burst, master holds BREADY=0 for 3 cycles -> no beats lost; m_BVALID held stable until handshake.
- W before AW: master asserts WVALID 3 cycles before AWVALID -> m_WREADY=0 until DATA; first beat routed to the correct slave.
- Reset mid-DATA: ARESET=1 for 1 cycle after beat 2 of 4 -> next cycle all outputs 0, state IDLE; a new AW to slave 0 completes normally.
- Back-to-back: transaction to slave 0, then slave 3 -> second AW accepted only after the first B handshake; no cross-talk on s_* valids.
